seq_packet_serializer: RTL and testbench



---
 rtl/seq_packet_serializer_if.sv | 64 ++++++
 rtl/seq_packet_serializer.sv | 99 +++++++++
 tb/tb_seq_packet_serializer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_packet_serializer_if.sv
// Handshake/data bundle between the compression core, the serializer and the
// sequence encoder: multi-lane packet in, single sequence out, debug counters.
`ifndef SEQ_PACKET_SIZE
`define SEQ_PACKET_SIZE 4
`endif
`ifndef SEQ_LL_BITS
`define SEQ_LL_BITS 8
`endif
`ifndef SEQ_ML_BITS
`define SEQ_ML_BITS 8
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 16
`endif

interface seq_packet_serializer_if #(
  parameter int PACKET_SIZE = `SEQ_PACKET_SIZE,
  parameter int LL_BITS     = `SEQ_LL_BITS,
  parameter int ML_BITS     = `SEQ_ML_BITS,
  parameter int OFFSET_BITS = `SEQ_OFFSET_BITS
);
  logic                               i_seq_packet_valid;
  logic                               i_seq_packet_ready;
  logic [PACKET_SIZE-1:0]             i_seq_packet_strb;
  logic [PACKET_SIZE*LL_BITS-1:0]     i_seq_packet_ll;
  logic [PACKET_SIZE*ML_BITS-1:0]     i_seq_packet_ml;
  logic [PACKET_SIZE*OFFSET_BITS-1:0] i_seq_packet_offset;
  logic [PACKET_SIZE*ML_BITS-1:0]     i_seq_packet_overlap;
  logic [PACKET_SIZE-1:0]             i_seq_packet_eoj;
  logic [PACKET_SIZE-1:0]             i_seq_packet_delim;

  logic                               o_seq_valid;
  logic                               o_seq_ready;
  logic [LL_BITS-1:0]                 o_seq_ll;
  logic [ML_BITS-1:0]                 o_seq_ml;
  logic [OFFSET_BITS-1:0]             o_seq_offset;
  logic [ML_BITS-1:0]                 o_seq_overlap;
  logic                               o_seq_eoj;
  logic                               o_seq_delim;
  logic                               o_seq_last;

  logic [31:0]                        o_stat_seq_cnt;
  logic [31:0]                        o_stat_job_cnt;

  // Serializer side
  modport slave (
    input  i_seq_packet_valid, i_seq_packet_strb, i_seq_packet_ll, i_seq_packet_ml,
           i_seq_packet_offset, i_seq_packet_overlap, i_seq_packet_eoj, i_seq_packet_delim,
           o_seq_ready,
    output i_seq_packet_ready,
           o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_overlap,
           o_seq_eoj, o_seq_delim, o_seq_last, o_stat_seq_cnt, o_stat_job_cnt
  );

  // Environment side (packet producer + sequence consumer)
  modport master (
    output i_seq_packet_valid, i_seq_packet_strb, i_seq_packet_ll, i_seq_packet_ml,
           i_seq_packet_offset, i_seq_packet_overlap, i_seq_packet_eoj, i_seq_packet_delim,
           o_seq_ready,
    input  i_seq_packet_ready,
           o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_overlap,
           o_seq_eoj, o_seq_delim, o_seq_last, o_stat_seq_cnt, o_stat_job_cnt
  );
endinterface

// File: rtl/seq_packet_serializer.sv
// Single-entry packet buffer that emits strobed lanes lowest-first, one per
// cycle, reloading on the last lane so packets stream without bubbles.
`ifndef SEQ_PACKET_SIZE
`define SEQ_PACKET_SIZE 4
`endif
`ifndef SEQ_LL_BITS
`define SEQ_LL_BITS 8
`endif
`ifndef SEQ_ML_BITS
`define SEQ_ML_BITS 8
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 16
`endif

module seq_packet_serializer #(
  parameter int PACKET_SIZE = `SEQ_PACKET_SIZE,
  parameter int LL_BITS     = `SEQ_LL_BITS,
  parameter int ML_BITS     = `SEQ_ML_BITS,
  parameter int OFFSET_BITS = `SEQ_OFFSET_BITS
) (
  input logic                    clk,
  input logic                    rst,
  seq_packet_serializer_if.slave bus
);
  localparam int SEL_W = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;

  typedef struct packed {
    logic [LL_BITS-1:0]     ll;
    logic [ML_BITS-1:0]     ml;
    logic [OFFSET_BITS-1:0] offset;
    logic [ML_BITS-1:0]     overlap;
    logic                   eoj;
    logic                   delim;
  } seq_t;

  seq_t [PACKET_SIZE-1:0] lane_in;
  seq_t [PACKET_SIZE-1:0] buf_q;
  seq_t                   cur;
  logic [PACKET_SIZE-1:0] pending;
  logic [SEL_W-1:0]       sel;
  logic                   full, last, out_fire, in_fire, load;
  logic [31:0]            seq_cnt, job_cnt;

  for (genvar k = 0; k < PACKET_SIZE; k++) begin : g_lane
    assign lane_in[k] = {bus.i_seq_packet_ll[k*LL_BITS +: LL_BITS],
                         bus.i_seq_packet_ml[k*ML_BITS +: ML_BITS],
                         bus.i_seq_packet_offset[k*OFFSET_BITS +: OFFSET_BITS],
                         bus.i_seq_packet_overlap[k*ML_BITS +: ML_BITS],
                         bus.i_seq_packet_eoj[k],
                         bus.i_seq_packet_delim[k]};
  end

  // Lowest pending lane wins: scan downward so the last hit is the lowest.
  always_comb begin
    sel = '0;
    for (int k = PACKET_SIZE - 1; k >= 0; k--)
      if (pending[k]) sel = SEL_W'(k);
  end

  assign full     = |pending;
  assign last     = $onehot(pending);
  assign cur      = buf_q[sel];
  assign out_fire = full & bus.o_seq_ready;
  assign bus.i_seq_packet_ready = ~full | (bus.o_seq_ready & last);
  assign in_fire  = bus.i_seq_packet_valid & bus.i_seq_packet_ready;
  assign load     = in_fire & (|bus.i_seq_packet_strb);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      buf_q   <= '0;
      seq_cnt <= '0;
      job_cnt <= '0;
    end else begin
      if (out_fire) begin
        pending[sel] <= 1'b0;
        seq_cnt      <= seq_cnt + 32'd1;
        if (cur.eoj) job_cnt <= job_cnt + 32'd1;
      end
      // A reload on the final lane overrides that lane's clear.
      if (load) begin
        pending <= bus.i_seq_packet_strb;
        buf_q   <= lane_in;
      end
    end
  end

  assign bus.o_seq_valid    = full;
  assign bus.o_seq_last     = last;
  assign bus.o_seq_ll       = cur.ll;
  assign bus.o_seq_ml       = cur.ml;
  assign bus.o_seq_offset   = cur.offset;
  assign bus.o_seq_overlap  = cur.overlap;
  assign bus.o_seq_eoj      = cur.eoj;
  assign bus.o_seq_delim    = cur.delim;
  assign bus.o_stat_seq_cnt = seq_cnt;
  assign bus.o_stat_job_cnt = job_cnt;
endmodule

// File: tb/tb_seq_packet_serializer.sv
// Scoreboard bench: accepted packets expand into an expected sequence queue;
// a negedge monitor compares outputs, handshake and counters against it.
module tb_seq_packet_serializer;
  localparam int P = 4, LLB = 8, MLB = 8, OFB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_packet_serializer_if #(.PACKET_SIZE(P), .LL_BITS(LLB), .ML_BITS(MLB), .OFFSET_BITS(OFB)) bus ();
  seq_packet_serializer #(.PACKET_SIZE(P), .LL_BITS(LLB), .ML_BITS(MLB), .OFFSET_BITS(OFB))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [LLB-1:0] ll;
    logic [MLB-1:0] ml;
    logic [OFB-1:0] off;
    logic [MLB-1:0] ovl;
    logic eoj;
    logic delim;
    logic last;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_pass = 0;
  int unsigned exp_seq = 0, exp_job = 0;
  bit          mon_en = 0, rdy_rand = 0;
  logic        rdy_q = 1'b1;

  logic [LLB-1:0] p_ll[P];
  logic [MLB-1:0] p_ml[P];
  logic [OFB-1:0] p_off[P];
  logic [MLB-1:0] p_ovl[P];
  logic [P-1:0]   p_eoj, p_delim;

  assign bus.o_seq_ready = rdy_q;
  always @(posedge clk) begin
    #1;
    rdy_q = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: expected state is entirely derived from the queue of owed sequences.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      logic exp_rdy;
      exp_rdy = 1'b1;
      if (q.size() != 0) exp_rdy = bus.o_seq_ready && q[0].last;
      chk("valid", 64'(bus.o_seq_valid), 64'(q.size() != 0));
      chk("pkt_ready", 64'(bus.i_seq_packet_ready), 64'(exp_rdy));
      chk("seq_cnt", 64'(bus.o_stat_seq_cnt), 64'(exp_seq));
      chk("job_cnt", 64'(bus.o_stat_job_cnt), 64'(exp_job));
      if (bus.o_seq_valid && q.size() != 0) begin
        chk("seq_fields",
            64'({bus.o_seq_ll, bus.o_seq_ml, bus.o_seq_offset, bus.o_seq_overlap,
                 bus.o_seq_eoj, bus.o_seq_delim, bus.o_seq_last}),
            64'(q[0]));
        if (bus.o_seq_ready) begin
          exp_seq++;
          if (q[0].eoj) exp_job++;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic rand_fields(input bit flags);
    for (int k = 0; k < P; k++) begin
      p_ll[k]  = LLB'($urandom);
      p_ml[k]  = MLB'($urandom);
      p_off[k] = OFB'($urandom);
      p_ovl[k] = MLB'($urandom);
    end
    p_eoj   = flags ? P'($urandom) : '0;
    p_delim = flags ? P'($urandom) : '0;
  endtask

  // Present one packet, wait for acceptance, then record what it owes downstream.
  task automatic send(input logic [P-1:0] strb);
    bit ok;
    int top;
    bus.i_seq_packet_strb  = strb;
    bus.i_seq_packet_eoj   = p_eoj;
    bus.i_seq_packet_delim = p_delim;
    for (int k = 0; k < P; k++) begin
      bus.i_seq_packet_ll[k*LLB +: LLB]      = p_ll[k];
      bus.i_seq_packet_ml[k*MLB +: MLB]      = p_ml[k];
      bus.i_seq_packet_offset[k*OFB +: OFB]  = p_off[k];
      bus.i_seq_packet_overlap[k*MLB +: MLB] = p_ovl[k];
    end
    bus.i_seq_packet_valid = 1'b1;
    ok = 0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (bus.i_seq_packet_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
    @(posedge clk);
    if (ok) begin
      top = -1;
      for (int k = 0; k < P; k++) if (strb[k]) top = k;
      for (int k = 0; k < P; k++)
        if (strb[k]) q.push_back('{p_ll[k], p_ml[k], p_off[k], p_ovl[k], p_eoj[k], p_delim[k], k == top});
    end
    #1;
    bus.i_seq_packet_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int w = 0; w < 300; w++) begin
      if (q.size() == 0) begin ok = 1; break; end
      @(posedge clk);
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d owed sequences expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_seq_packet_valid = 1'b0;
    bus.i_seq_packet_strb = '0; bus.i_seq_packet_eoj = '0; bus.i_seq_packet_delim = '0;
    bus.i_seq_packet_ll = '0; bus.i_seq_packet_ml = '0;
    bus.i_seq_packet_offset = '0; bus.i_seq_packet_overlap = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        64'({bus.o_seq_valid, bus.o_seq_last, bus.i_seq_packet_ready, bus.o_seq_ll, bus.o_seq_ml,
             bus.o_seq_offset, bus.o_seq_overlap, bus.o_seq_eoj, bus.o_seq_delim}),
        64'({1'b0, 1'b0, 1'b1, 42'd0}));
    chk("reset_counters", {bus.o_stat_seq_cnt, bus.o_stat_job_cnt}, 64'd0);
    mon_en = 1;
    @(posedge clk); #1;

    // Single packet, lanes 0,1,3
    rand_fields(0);
    p_ll[0] = 8'd5; p_ll[1] = 8'd7; p_ll[3] = 8'd9;
    send(4'b1011);
    drain();
    chk("t1_seq_cnt", 64'(bus.o_stat_seq_cnt), 64'd3);

    // Back-to-back, continuous ready
    rand_fields(0); send(4'b1111);
    rand_fields(0); send(4'b0001);
    drain();

    // Backpressure mid-packet
    rdy_rand = 1;
    rand_fields(0); send(4'b1111);
    rand_fields(0); send(4'b0110);
    drain();
    rdy_rand = 0;

    // Empty-strobe packet between two full ones; its flags must be ignored
    rand_fields(0); send(4'b1111);
    rand_fields(1); p_eoj = 4'b1111; send(4'b0000);
    rand_fields(0); send(4'b1111);
    drain();

    // Reset with two lanes still pending
    rand_fields(1); send(4'b1111);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    q.delete(); exp_seq = 0; exp_job = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid", 64'({bus.o_seq_valid, bus.i_seq_packet_ready, bus.o_stat_seq_cnt, bus.o_stat_job_cnt}),
        64'({1'b0, 1'b1, 64'd0}));
    @(posedge clk); #1;

    // eoj on lane 2 then lane 0 of the next packet, delim on final lane
    rand_fields(0); p_eoj = 4'b0100; send(4'b0111);
    rand_fields(0); p_eoj = 4'b0001; p_delim = 4'b0010; send(4'b0011);
    drain();
    chk("t5_job_cnt", 64'(bus.o_stat_job_cnt), 64'd2);
    chk("t5_seq_cnt", 64'(bus.o_stat_seq_cnt), 64'd5);

    // Randomized traffic with random backpressure and idle gaps
    rdy_rand = 1;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      rand_fields(1);
      send(P'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
